// File: rtl/data_mem_responder.sv
// data_mem_responder
// Word-addressed main data memory that answers the cache/memory handshake.
// A read or write request is latched in IDLE, waits a programmable number of
// cycles, then is answered with a registered MemReadReady/memReadData pair or
// a MemWriteDone flag that is held until the requester releases its request.
// Address bits [1:0] and everything above the word index are ignored. This
// makes the array alias modulo DEPTH_WORDS and drops the supervisor bit.

module data_mem_responder #(
    parameter int DEPTH_WORDS   = 1024,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemReadDone,
    input  logic        MemWriteReady,
    input  logic [31:0] memAddr,
    input  logic [31:0] memWriteData,
    output logic [31:0] memReadData,
    output logic        MemReadReady,
    output logic        MemWriteDone
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    // The counter is loaded with latency-1 because the edge that sees zero
    // is itself the edge that raises the response flag.
    localparam logic [7:0] RD_CNT_INIT = 8'(READ_LATENCY - 1);
    localparam logic [7:0] WR_CNT_INIT = 8'(WRITE_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_HOLD,
        WR_WAIT,
        WR_HOLD
    } state_t;

    state_t             state_reg;
    logic [7:0]         count_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [31:0]        wdata_reg;

    // Storage array; not cleared by reset so it maps onto block RAM.
    logic [31:0]        mem_reg [DEPTH_WORDS];

    logic [IDX_W-1:0]   req_idx;
    logic               mem_we;
    logic               unused_addr_bits;

    // Word index of the incoming request; the upper bits and the byte offset
    // are deliberately discarded.
    assign req_idx = memAddr[IDX_W+1:2];
    assign unused_addr_bits = ^{memAddr[31:IDX_W+2], memAddr[1:0]};

    // The array commits on the edge the write wait expires. A request that
    // drops on that same edge, or a reset sampled on it, suppresses the commit.
    assign mem_we = (state_reg == WR_WAIT) && MemWriteReady &&
                    (count_reg == 8'd0) && !reset;

    // Handshake sequencer with registered outputs and a latency counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            count_reg    <= 8'd0;
            MemReadReady <= 1'b0;
            MemWriteDone <= 1'b0;
            memReadData  <= 32'd0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    // A read takes priority. A simultaneous write stays
                    // pending at the input and is accepted once the read
                    // handshake has finished.
                    if (MemRead) begin
                        idx_reg   <= req_idx;
                        count_reg <= RD_CNT_INIT;
                        state_reg <= RD_WAIT;
                    end else if (MemWriteReady) begin
                        idx_reg   <= req_idx;
                        wdata_reg <= memWriteData;
                        count_reg <= WR_CNT_INIT;
                        state_reg <= WR_WAIT;
                    end
                end

                RD_WAIT: begin
                    if (!MemRead) begin
                        // The requester gave up, so no response is sent.
                        count_reg <= 8'd0;
                        state_reg <= IDLE;
                    end else if (count_reg != 8'd0) begin
                        count_reg <= count_reg - 8'd1;
                    end else begin
                        memReadData  <= mem_reg[idx_reg];
                        MemReadReady <= 1'b1;
                        state_reg    <= RD_HOLD;
                    end
                end

                RD_HOLD: begin
                    // Data stays stable until it is consumed or the request
                    // is withdrawn. The return through IDLE gives the
                    // mandatory dead cycle.
                    if (MemReadDone || !MemRead) begin
                        MemReadReady <= 1'b0;
                        memReadData  <= 32'd0;
                        state_reg    <= IDLE;
                    end
                end

                WR_WAIT: begin
                    if (!MemWriteReady) begin
                        // The write is withdrawn before commit, so the array
                        // is left untouched.
                        count_reg <= 8'd0;
                        state_reg <= IDLE;
                    end else if (count_reg != 8'd0) begin
                        count_reg <= count_reg - 8'd1;
                    end else begin
                        MemWriteDone <= 1'b1;
                        state_reg    <= WR_HOLD;
                    end
                end

                WR_HOLD: begin
                    if (!MemWriteReady) begin
                        MemWriteDone <= 1'b0;
                        state_reg    <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Array write port, using the index and data latched at acceptance.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_reg[idx_reg] <= wdata_reg;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
// Randomised scoreboard bench for data_mem_responder. The driver tasks work
// out each expected response from a word-indexed reference memory. Each
// expectation holds the data and the cycle of the response, and goes into a
// queue. An independent monitor pops an entry on every response edge and
// compares it with what the DUT presents.

module tb_data_mem_responder;

    localparam int DEPTH = 1024;
    localparam int RL    = 4;
    localparam int WL    = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead;
    logic        MemReadDone;
    logic        MemWriteReady;
    logic [31:0] memAddr;
    logic [31:0] memWriteData;
    logic [31:0] memReadData;
    logic        MemReadReady;
    logic        MemWriteDone;

    data_mem_responder #(
        .DEPTH_WORDS  (DEPTH),
        .READ_LATENCY (RL),
        .WRITE_LATENCY(WL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .MemRead      (MemRead),
        .MemReadDone  (MemReadDone),
        .MemWriteReady(MemWriteReady),
        .memAddr      (memAddr),
        .memWriteData (memWriteData),
        .memReadData  (memReadData),
        .MemReadReady (MemReadReady),
        .MemWriteDone (MemWriteDone)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        rd_q[$];
    exp_t        wr_q[$];
    logic [31:0] model_mem [int];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    int pool [16] = '{0, 4, 8, 12, 1, 2, 100, 255, 256, 511, 512, 700, 900, 1000, 1022, 1023};

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, req, cyc);
        end
    endtask

    function automatic int idx_of(input logic [31:0] addr);
        return int'((addr >> 2) % DEPTH);
    endfunction

    function automatic logic [31:0] mk_addr(input int idx);
        return ($urandom & 32'hFFFF_F003) | (32'(idx) << 2);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_flag(input bit is_rd, input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            if ((is_rd ? MemReadReady : MemWriteDone) === 1'b1) seen = 1'b1;
            else tick();
        end
    endtask

    // Monitor: response edges pop the scoreboard; held data must stay put.
    logic        prev_rr = 1'b0;
    logic        prev_wd = 1'b0;
    logic [31:0] prev_data = 32'd0;
    always @(negedge clk) begin
        exp_t e;
        if (MemReadReady === 1'b1 && !prev_rr) begin
            if (rd_q.size() == 0) begin
                chk("rd_unexpected", 32'd1, 32'd0);
            end else begin
                e = rd_q.pop_front();
                chk("rd_data", memReadData, e.data);
                chk("rd_latency_cycle", 32'(cyc), 32'(e.cyc));
            end
        end else if (MemReadReady === 1'b1 && prev_rr) begin
            chk("rd_hold_stable", memReadData, prev_data);
        end
        if (MemWriteDone === 1'b1 && !prev_wd) begin
            if (wr_q.size() == 0) begin
                chk("wr_unexpected", 32'd1, 32'd0);
            end else begin
                e = wr_q.pop_front();
                chk("wr_latency_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        prev_rr   = (MemReadReady === 1'b1);
        prev_wd   = (MemWriteDone === 1'b1);
        prev_data = memReadData;
    end

    // Called just after the accept edge of a write.
    task automatic finish_write(input int hold);
        bit seen;
        memAddr      = $urandom;
        memWriteData = $urandom;
        wait_flag(1'b0, WL + 4, seen);
        chk("wr_timeout", 32'(seen), 32'd1);
        if (!seen) wr_q.delete();
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("wr_done_held", 32'(MemWriteDone), 32'd1);
        end
        MemWriteReady = 1'b0;
        tick();
        chk("wr_done_release", 32'(MemWriteDone), 32'd0);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input int hold);
        memAddr       = addr;
        memWriteData  = data;
        MemWriteReady = 1'b1;
        wr_q.push_back('{data: data, cyc: cyc + 1 + WL});
        model_mem[idx_of(addr)] = data;
        tick();
        finish_write(hold);
    endtask

    // Called just after the accept edge of a read.
    task automatic finish_read(input int hold, input bit by_drop);
        bit seen;
        wait_flag(1'b1, RL + 4, seen);
        chk("rd_timeout", 32'(seen), 32'd1);
        if (!seen) rd_q.delete();
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("rd_ready_held", 32'(MemReadReady), 32'd1);
        end
        if (by_drop) MemRead = 1'b0;
        else MemReadDone = 1'b1;
        tick();
        chk("rd_ready_release", 32'(MemReadReady), 32'd0);
        chk("rd_data_release", memReadData, 32'd0);
        MemRead     = 1'b0;
        MemReadDone = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input int hold, input bit by_drop);
        memAddr = addr;
        MemRead = 1'b1;
        rd_q.push_back('{data: model_mem[idx_of(addr)], cyc: cyc + 1 + RL});
        tick();
        memAddr = $urandom;
        finish_read(hold, by_drop);
    endtask

    task automatic do_both(input logic [31:0] addr, input logic [31:0] data);
        memAddr       = addr;
        memWriteData  = data;
        MemRead       = 1'b1;
        MemWriteReady = 1'b1;
        rd_q.push_back('{data: model_mem[idx_of(addr)], cyc: cyc + 1 + RL});
        tick();
        finish_read(0, 1'b0);
        memAddr      = addr;
        memWriteData = data;
        wr_q.push_back('{data: data, cyc: cyc + 1 + WL});
        model_mem[idx_of(addr)] = data;
        tick();
        finish_write(0);
    endtask

    task automatic do_read_abort(input logic [31:0] addr, input int j);
        memAddr = addr;
        MemRead = 1'b1;
        tick();
        for (int i = 0; i < j; i++) tick();
        MemRead = 1'b0;
        for (int i = 0; i < RL + 3; i++) tick();
        chk("rd_abort_no_ready", 32'(MemReadReady), 32'd0);
    endtask

    task automatic do_write_abort(input logic [31:0] addr, input logic [31:0] data, input int j);
        memAddr       = addr;
        memWriteData  = data;
        MemWriteReady = 1'b1;
        tick();
        for (int i = 0; i < j; i++) tick();
        MemWriteReady = 1'b0;
        for (int i = 0; i < WL + 3; i++) tick();
        chk("wr_abort_no_done", 32'(MemWriteDone), 32'd0);
    endtask

    task automatic do_write_reset(input logic [31:0] addr, input logic [31:0] data);
        memAddr       = addr;
        memWriteData  = data;
        MemWriteReady = 1'b1;
        tick();
        tick();
        reset         = 1'b1;
        MemWriteReady = 1'b0;
        tick();
        chk("wr_reset_done", 32'(MemWriteDone), 32'd0);
        chk("wr_reset_ready", 32'(MemReadReady), 32'd0);
        reset = 1'b0;
        tick();
    endtask

    task automatic do_read_reset(input logic [31:0] addr);
        bit seen;
        memAddr = addr;
        MemRead = 1'b1;
        rd_q.push_back('{data: model_mem[idx_of(addr)], cyc: cyc + 1 + RL});
        tick();
        wait_flag(1'b1, RL + 4, seen);
        chk("rdrst_timeout", 32'(seen), 32'd1);
        if (!seen) rd_q.delete();
        reset   = 1'b1;
        MemRead = 1'b0;
        tick();
        chk("rdrst_ready", 32'(MemReadReady), 32'd0);
        chk("rdrst_data", memReadData, 32'd0);
        reset = 1'b0;
        tick();
    endtask

    initial begin
        int kind;
        int idx;
        reset         = 1'b1;
        MemRead       = 1'b0;
        MemReadDone   = 1'b0;
        MemWriteReady = 1'b0;
        memAddr       = 32'd0;
        memWriteData  = 32'd0;
        repeat (3) tick();
        chk("reset_rd_ready", 32'(MemReadReady), 32'd0);
        chk("reset_wr_done", 32'(MemWriteDone), 32'd0);
        chk("reset_rd_data", memReadData, 32'd0);
        reset = 1'b0;
        tick();

        // Give every word the bench will touch a known value.
        foreach (pool[i]) do_write(32'(pool[i]) << 2, $urandom, 0);

        // Write, then read back.
        do_write(32'h10, 32'hDEAD_BEEF, 0);
        do_read(32'h10, 0, 1'b0);

        // Simultaneous requests: the read sees the old value first.
        do_write(32'h20, 32'h0000_AAAA, 0);
        do_both(32'h20, 32'h0000_1234);
        do_read(32'h20, 0, 1'b0);

        // Long hold in RD_HOLD.
        do_read(32'h10, 10, 1'b0);

        // A reset during the write wait drops the write.
        do_write_reset(32'h30, 32'h5555_5555);
        do_read(32'h30, 0, 1'b0);
        do_read_reset(32'h10);

        // Index wrap, ignored byte offset and ignored supervisor bit.
        do_write(32'h0000_1000, 32'hCAFE_F00D, 1);
        do_read(32'h0000_0000, 0, 1'b0);
        do_read(32'h8000_0003, 0, 1'b0);

        // Aborted read, then a normal read.
        do_read_abort(32'h10, 2);
        do_read(32'h10, 1, 1'b1);
        do_write_abort(32'h10, 32'h0BAD_0BAD, WL - 1);
        do_read(32'h10, 0, 1'b0);

        for (int n = 0; n < 150; n++) begin
            kind = int'($urandom % 6);
            idx  = pool[$urandom % 16];
            case (kind)
                0, 1: do_write(mk_addr(idx), $urandom, int'($urandom % 3));
                2:    do_read(mk_addr(idx), int'($urandom % 4), 1'($urandom % 2));
                3:    do_read_abort(mk_addr(idx), int'($urandom % RL));
                4:    do_write_abort(mk_addr(idx), $urandom, int'($urandom % WL));
                default: do_both(mk_addr(idx), $urandom);
            endcase
            repeat ($urandom % 3) tick();
        end

        repeat (4) tick();
        chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);
        chk("wr_queue_drained", 32'(wr_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
